// File: rtl/csel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csel_pkg
// Description : Shared definitions for the pipelined carry-select adder.
//               Sizing helpers that turn the operand width, slice size and
//               slices-per-stage into the slice count and stage count, plus
//               the control part of the per-stage payload.
// Revision    : 1.0 - initial parametrised, pipelined release
// ============================================================================
package csel_pkg;

    // Integer ceiling division. A zero divisor yields 0 so that illegal
    // parameter sets reach the elaboration-time checks instead of a
    // divide-by-zero inside a constant expression.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        if (d == 0) begin
            return 0;
        end
        return (n + d - 1) / d;
    endfunction

    // Number of carry-select slices across the operand.
    function automatic int unsigned num_blk(input int unsigned width, input int unsigned block);
        if (block == 0) begin
            return 0;
        end
        return width / block;
    endfunction

    // Number of pipeline stages. Never below 1, so array sizes stay legal
    // even when the parameter checks are about to reject the configuration.
    function automatic int unsigned num_stg(input int unsigned width, input int unsigned block,
                                            input int unsigned blk_per_stg);
        int unsigned n;
        n = ceil_div(num_blk(width, block), blk_per_stg);
        return (n == 0) ? 1 : n;
    endfunction

    // Control fields carried alongside the data in every stage register.
    //   valid : this slot holds a live operation
    //   carry : carry out of the highest slice resolved so far
    //   ovf   : signed overflow, only meaningful after the last stage
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } csel_ctl_t;

endpackage : csel_pkg
`default_nettype wire

// File: rtl/csel_block.sv
`default_nettype none
// ============================================================================
// Module      : csel_block
// Description : One BLOCK-bit carry-select slice. With FIRST set it is a
//               plain ripple adder driven by the real carry-in. Otherwise it
//               evaluates two ripple chains (carry-in 0 and carry-in 1) and
//               picks one with the incoming carry, so the slice's own delay
//               overlaps with the carry arriving from below.
// Revision    : 1.0 - initial release
//
// Ports
//   i_a, i_b : BLOCK-bit operand slices (i_b already inverted for subtract)
//   i_cin    : carry into the slice
//   o_sum    : BLOCK-bit sum slice
//   o_cout   : carry out of the slice
// ============================================================================
module csel_block #(
    parameter int unsigned BLOCK = 4,
    parameter bit          FIRST = 1'b0
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout
);

    // Bit-serial full-adder chain. Returns {carry_out, sum}.
    function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             ci);
        logic [BLOCK:0] r;
        logic           c;
        c = ci;
        for (int i = 0; i < BLOCK; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[BLOCK] = c;
        return r;
    endfunction

    if (FIRST) begin : g_ripple
        logic [BLOCK:0] w_r;

        assign w_r    = ripple(i_a, i_b, i_cin);
        assign o_sum  = w_r[BLOCK-1:0];
        assign o_cout = w_r[BLOCK];
    end else begin : g_select
        logic [BLOCK:0] w_r0;
        logic [BLOCK:0] w_r1;

        // Both outcomes are ready before the carry arrives; the carry only
        // steers the final mux.
        assign w_r0            = ripple(i_a, i_b, 1'b0);
        assign w_r1            = ripple(i_a, i_b, 1'b1);
        assign {o_cout, o_sum} = i_cin ? w_r1 : w_r0;
    end

endmodule : csel_block
`default_nettype wire

// File: rtl/csel_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csel_adder_pipe
// Description : Parametrised, pipelined carry-select adder/subtractor with a
//               valid/ready handshake. Stage k resolves a group of
//               BLK_PER_STG slices and registers the low sum bits resolved
//               so far, the running carry and the operands still to be
//               added. A stalled output freezes the whole pipeline.
// Revision    : 1.0 - initial release
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears every stage
//   in_valid  : operands and mode present this cycle
//   in_ready  : operands accepted this cycle (low only while stalled)
//   a, b      : WIDTH-bit operands
//   cin       : carry-in, ignored in subtract mode
//   sub       : 0 -> a+b+cin, 1 -> a-b
//   out_valid : result present
//   out_ready : consumer takes the result
//   sum       : WIDTH-bit result
//   cout      : carry out of the MSB (no-borrow when subtracting)
//   ovf       : two's-complement signed overflow
// ============================================================================
module csel_adder_pipe
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BLOCK       = 4,
    parameter int unsigned BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned c_nblk = num_blk(WIDTH, BLOCK);
    localparam int unsigned c_nstg = num_stg(WIDTH, BLOCK, BLK_PER_STG);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (BLOCK < 2) begin : g_bad_block
        $fatal(1, "csel_adder_pipe: BLOCK=%0d must be at least 2", BLOCK);
    end else if ((WIDTH == 0) || ((WIDTH % BLOCK) != 0)) begin : g_bad_width
        $fatal(1, "csel_adder_pipe: WIDTH=%0d must be a non-zero multiple of BLOCK=%0d",
               WIDTH, BLOCK);
    end else if (BLK_PER_STG < 1) begin : g_bad_bps
        $fatal(1, "csel_adder_pipe: BLK_PER_STG=%0d must be at least 1", BLK_PER_STG);
    end

    // Per-stage payload. 's' holds the resolved low sum bits; the upper
    // part of 'a'/'b' holds the operand bits still to be added. Bits that
    // are already resolved simply travel along unused.
    typedef struct packed {
        csel_ctl_t        ctl;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t r_stg [c_nstg];
    stage_t w_nxt [c_nstg];
    stage_t w_prep;
    logic   w_stall;
    logic   w_unused;

    // ------------------------------------------------------------------
    // Operand preparation: subtract is a + ~b + 1.
    // ------------------------------------------------------------------
    always_comb begin
        w_prep           = '0;
        w_prep.ctl.valid = in_valid;
        w_prep.ctl.carry = sub ? 1'b1 : cin;
        w_prep.a         = a;
        w_prep.b         = sub ? ~b : b;
    end

    // ------------------------------------------------------------------
    // Stage datapaths
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_nstg; k++) begin : g_stage
        localparam int unsigned c_lo   = k * BLK_PER_STG;
        localparam int unsigned c_hi   = (((k + 1) * BLK_PER_STG) < c_nblk) ?
                                         ((k + 1) * BLK_PER_STG) : c_nblk;
        localparam int unsigned c_n    = c_hi - c_lo;
        localparam bit          c_last = (k == c_nstg - 1);

        stage_t               w_in;
        stage_t               w_out;
        logic [c_n*BLOCK-1:0] w_s;

        if (k == 0) begin : g_src_port
            assign w_in = w_prep;
        end else begin : g_src_reg
            assign w_in = r_stg[k-1];
        end

        for (genvar j = 0; j < c_n; j++) begin : g_slice
            localparam int unsigned c_bit = (c_lo + j) * BLOCK;

            logic w_ci;
            logic w_co;

            // The first slice of a stage takes the registered running
            // carry; the rest chain within the stage.
            if (j == 0) begin : g_ci_stage
                assign w_ci = w_in.ctl.carry;
            end else begin : g_ci_chain
                assign w_ci = g_slice[j-1].w_co;
            end

            csel_block #(
                .BLOCK (BLOCK),
                .FIRST ((c_lo + j) == 0)
            ) u_blk (
                .i_a    (w_in.a[c_bit +: BLOCK]),
                .i_b    (w_in.b[c_bit +: BLOCK]),
                .i_cin  (w_ci),
                .o_sum  (w_s[j*BLOCK +: BLOCK]),
                .o_cout (w_co)
            );
        end

        always_comb begin
            w_out                           = w_in;
            w_out.s[c_lo*BLOCK +: c_n*BLOCK] = w_s;
            w_out.ctl.carry                 = g_slice[c_n-1].w_co;
            w_out.ctl.ovf                   = 1'b0;
            if (c_last) begin
                // Carry into the MSB is recovered from a ^ b ^ sum there;
                // overflow is that carry XOR the carry out.
                w_out.ctl.ovf = w_in.a[WIDTH-1] ^ w_in.b[WIDTH-1] ^
                                w_out.s[WIDTH-1] ^ w_out.ctl.carry;
            end
        end

        assign w_nxt[k] = w_out;
    end

    // ------------------------------------------------------------------
    // Stage registers: a stall freezes every stage so no bubble is
    // squeezed out and ordering is preserved.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_nstg; k++) begin
                r_stg[k] <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < c_nstg; k++) begin
                r_stg[k] <= w_nxt[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake and outputs
    // ------------------------------------------------------------------
    assign w_stall   = r_stg[c_nstg-1].ctl.valid && !out_ready;
    assign in_ready  = !w_stall;

    assign out_valid = r_stg[c_nstg-1].ctl.valid;
    assign sum       = r_stg[c_nstg-1].s;
    assign cout      = r_stg[c_nstg-1].ctl.carry;
    assign ovf       = r_stg[c_nstg-1].ctl.ovf;

    // Operand bits in the last register have nothing left to feed.
    assign w_unused  = ^{r_stg[c_nstg-1].a, r_stg[c_nstg-1].b};

endmodule : csel_adder_pipe
`default_nettype wire

// File: tb/tb_csel_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_csel_adder_pipe
// Description : Self-checking bench for csel_adder_pipe. A 32-bit, 4-stage
//               instance is driven with directed and random traffic and
//               compared against an arithmetic reference model through an
//               in-order scoreboard; a 16-bit single-stage instance covers
//               the degenerate configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csel_adder_pipe;

    localparam int unsigned NSTG = 4;   // 32/4 = 8 slices, 2 per stage

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready;
    logic        d1_cout, d1_ovf;
    logic [15:0] d1_a, d1_b, d1_sum;

    csel_adder_pipe #(.WIDTH(32), .BLOCK(4), .BLK_PER_STG(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    csel_adder_pipe #(.WIDTH(16), .BLOCK(4), .BLK_PER_STG(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin), .sub(d1_sub), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    res_t        exp_q[$];
    bit          held_v = 1'b0;
    logic [34:0] held;
    bit          last_acc, last_dlv, last_stall, last_inready;
    logic [31:0] last_sum;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w.
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic s);
        res_t        r;
        logic [64:0] t;
        logic [63:0] mask;
        longint      sx, sy, val, lim;
        mask = (64'd1 << w) - 64'd1;
        if (s) t = {1'b0, x} - {1'b0, y} + (65'd1 << w);  // bit w set iff no borrow
        else   t = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        r.sum  = t[63:0] & mask;
        r.cout = t[w];
        sx = longint'(x);
        if (x[w-1]) sx = sx - longint'(64'd1 << w);
        sy = longint'(y);
        if (y[w-1]) sy = sy - longint'(64'd1 << w);
        val   = s ? (sx - sy) : (sx + sy + (ci ? 64'sd1 : 64'sd0));
        lim   = longint'(64'd1 << (w - 1));
        r.ovf = (val >= lim) || (val < -lim);
        return r;
    endfunction

    // One clock cycle on the 32-bit instance. Entered 1 time unit after a
    // rising edge with inputs applied; samples just before the next edge.
    task automatic step();
        res_t e;
        #3;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (held_v) chk("hold_stable", {out_valid, cout, ovf, sum}, held);
        held_v       = out_valid && !out_ready;
        held         = {out_valid, cout, ovf, sum};
        last_stall   = out_valid && !out_ready;
        last_inready = in_ready;
        last_acc     = in_valid && in_ready;
        last_dlv     = out_valid && out_ready;
        last_sum     = sum;
        if (last_dlv) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
            end
        end
        if (last_acc) exp_q.push_back(model(32, a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                            input logic xc, input logic xs, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, NSTG);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        step();
    endtask

    task automatic run_stream();
        int i, got, c, n_stall;
        i = 0; got = 0; c = 0; n_stall = 0;
        while (got < 8 && c < 60) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (i < 8);
            a = i; b = 100 * i; cin = 1'b0; sub = 1'b0;
            step();
            if (last_stall) begin
                n_stall++;
                chk("stream_in_ready_stall", last_inready, 1'b0);
            end
            if (last_acc) i++;
            if (last_dlv) begin
                chk("stream_order", last_sum, 101 * got);
                got++;
            end
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 8);
        chk("stream_stall_cycles", n_stall, 3);
        for (int k = 0; k < 6; k++) step();
        chk("stream_queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_reset();
        bit seen;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 10 + k; b = 20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("rst_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_sum", sum, 32'h0);
        chk("rst_async_cout", cout, 1'b0);
        chk("rst_async_in_ready", in_ready, 1'b1);
        exp_q.delete();
        held_v = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | out_valid;
            step();
        end
        chk("rst_no_stale_result", seen, 1'b0);
        directed("rst_new_op", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
    endtask

    task automatic run_random();
        logic [31:0] pick [5];
        pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h7FFF_FFFF;
        pick[3] = 32'h8000_0000; pick[4] = 32'h0000_0001;
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            cin = $urandom_range(0, 1);
            sub = $urandom_range(0, 1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk("random_drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_single_stage();
        res_t e;
        d1_a = 16'hABCD; d1_b = 16'h1234; d1_cin = 1'b1; d1_sub = 1'b0;
        d1_in_valid = 1'b1; d1_out_ready = 1'b1;
        #3;
        chk("s1_in_ready", d1_in_ready, 1'b1);
        @(posedge clk);
        #1;
        d1_in_valid = 1'b0;
        chk("s1_latency_valid", d1_out_valid, 1'b1);
        chk("s1_sum", d1_sum, 16'hBE02);
        chk("s1_cout", d1_cout, 1'b0);
        @(posedge clk);
        #1;
        chk("s1_bubble", d1_out_valid, 1'b0);
        for (int k = 0; k < 24; k++) begin
            d1_a   = (k == 0) ? 16'h7FFF : 16'($urandom);
            d1_b   = (k == 0) ? 16'h0001 : 16'($urandom);
            d1_cin = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            d1_sub = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            d1_in_valid = 1'b1;
            e = model(16, d1_a, d1_b, d1_cin, d1_sub);
            @(posedge clk);
            #1;
            chk("s1_rand_valid", d1_out_valid, 1'b1);
            chk("s1_rand_sum", d1_sum, e.sum);
            chk("s1_rand_cout", d1_cout, e.cout);
            chk("s1_rand_ovf", d1_ovf, e.ovf);
        end
        d1_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0;
        d1_out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sum", sum, 32'h0);
        chk("reset_cout", cout, 1'b0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_s1_out_valid", d1_out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("add_wrap",     32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
        directed("sub_neg",      32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_pos",      32'd7,         32'd5, 1'b0, 1'b1, 32'h2,         1'b1, 1'b0);
        directed("add_ovf",      32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_ovf",      32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_cin_span", 32'h0000_00FF, 32'h0000_0F00, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0);

        run_stream();
        run_reset();
        run_random();
        run_single_stage();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_csel_adder_pipe
`default_nettype wire
